// File: rtl/pong_if.sv
// Pong engine bus: game-rate strobe, start and paddle buttons in; board and
// score state out. The master side is the game controller, the slave side is
// the engine.
interface pong_if #(
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int SCORE_W = 7
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);

    logic               tick;
    logic               start;
    logic               btn_l1;
    logic               btn_r1;
    logic               btn_l2;
    logic               btn_r2;
    logic [YW-1:0]      paddle1;
    logic [YW-1:0]      paddle2;
    logic [XW-1:0]      ball_x;
    logic [YW-1:0]      ball_y;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [2:0]         state;
    logic [1:0]         winner;

    modport master (
        output tick, start, btn_l1, btn_r1, btn_l2, btn_r2,
        input  paddle1, paddle2, ball_x, ball_y, score1, score2, state, winner
    );

    modport slave (
        input  tick, start, btn_l1, btn_r1, btn_l2, btn_r2,
        output paddle1, paddle2, ball_x, ball_y, score1, score2, state, winner
    );
endinterface

// File: rtl/pong_engine.sv
// Two-player Pong engine for a COLS x ROWS LED board. Everything advances only
// on the one-cycle game tick; the clock itself is never gated or derived.
// Optional feature macro: PONG_SPEEDUP_EN -- ball step interval shrinks by one
// tick every 4 paddle returns (minimum 1), restored at every serve.
module pong_engine #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int PADDLE_W    = 3,
    parameter int WIN_SCORE   = 99,
    parameter int SCORE_W     = 7,
    parameter int STEP_TICKS  = 4,
    parameter int SERVE_TICKS = 8,
    parameter int POINT_TICKS = 8
) (
    input  logic  clk,
    input  logic  reset,
    pong_if.slave bus
);
    localparam int XW     = $clog2(COLS);
    localparam int YW     = $clog2(ROWS);
    localparam int PMAX   = ROWS - PADDLE_W;
    localparam int TMAX_A = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int TMAX   = (TMAX_A > STEP_TICKS) ? TMAX_A : STEP_TICKS;
    localparam int CW     = $clog2(TMAX + 1);

    localparam logic [YW-1:0]      P_HOME   = YW'((ROWS - PADDLE_W) / 2);
    localparam logic [YW-1:0]      Y_MID    = YW'(ROWS / 2);
    localparam logic [YW-1:0]      Y_TOP    = YW'(ROWS - 1);
    localparam logic [XW-1:0]      X_MID    = XW'(COLS / 2);
    localparam logic [XW-1:0]      X_L1     = XW'(1);
    localparam logic [XW-1:0]      X_R1     = XW'(COLS - 2);
    localparam logic [XW-1:0]      X_GOAL_R = XW'(COLS - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    // Vertical direction encoding: 0, +1, -1 (two's complement)
    localparam logic [1:0] DY_0   = 2'b00;
    localparam logic [1:0] DY_POS = 2'b01;
    localparam logic [1:0] DY_NEG = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t             state_q;
    logic [YW-1:0]      paddle1_q, paddle2_q, ball_y_q;
    logic [XW-1:0]      ball_x_q;
    logic               dx_q;          // 1 = moving toward player2, 0 = toward player1
    logic [1:0]         dy_q;
    logic [SCORE_W-1:0] score1_q, score2_q;
    logic [1:0]         winner_q;
    logic [CW-1:0]      cnt_q;         // tick counter shared by SERVE, PLAY and POINT
`ifdef PONG_SPEEDUP_EN
    logic [CW-1:0]      interval_q;    // current ticks per ball step
    logic [1:0]         rally_q;       // returns modulo 4 since the serve
`endif

    logic [YW-1:0] paddle1_d, paddle2_d, ball_y_d, pad_sel, off;
    logic [XW-1:0] ball_x_d;
    logic          dx_d, at_left, at_right, hit;
    logic [1:0]    dy_d;
    logic          step_due, enter_serve, serve_p2;

    // One-cell paddle move with saturation; opposite buttons cancel
    function automatic logic [YW-1:0] paddle_move(input logic [YW-1:0] p,
                                                  input logic l, input logic r);
        if (l && !r && p != '0)
            return p - 1'b1;
        if (r && !l && p != YW'(PMAX))
            return p + 1'b1;
        return p;
    endfunction

    assign paddle1_d = paddle_move(paddle1_q, bus.btn_l1, bus.btn_r1);
    assign paddle2_d = paddle_move(paddle2_q, bus.btn_l2, bus.btn_r2);

    // Next ball direction and position: paddle bounce first, then walls
    always_comb begin
        at_left  = (ball_x_q == X_L1) && !dx_q;
        at_right = (ball_x_q == X_R1) && dx_q;
        pad_sel  = dx_q ? paddle2_q : paddle1_q;
        off      = ball_y_q - pad_sel;
        hit      = (at_left || at_right) && (ball_y_q >= pad_sel) && (off < YW'(PADDLE_W));
        dx_d     = dx_q;
        dy_d     = dy_q;
        if (hit) begin
            dx_d = !dx_q;
            if (off == '0)
                dy_d = DY_NEG;
            else if (off == YW'(PADDLE_W - 1))
                dy_d = DY_POS;
        end
        if (ball_y_q == '0 && dy_d == DY_NEG)
            dy_d = DY_POS;
        else if (ball_y_q == Y_TOP && dy_d == DY_POS)
            dy_d = DY_NEG;
        ball_x_d = dx_d ? ball_x_q + 1'b1 : ball_x_q - 1'b1;
        case (dy_d)
            DY_POS:  ball_y_d = ball_y_q + 1'b1;
            DY_NEG:  ball_y_d = ball_y_q - 1'b1;
            default: ball_y_d = ball_y_q;
        endcase
    end

`ifdef PONG_SPEEDUP_EN
    assign step_due = (cnt_q >= interval_q - 1'b1);
`else
    assign step_due = (cnt_q == CW'(STEP_TICKS - 1));
`endif

    // Decide whether this tick (re)starts a serve, and who serves
    always_comb begin
        enter_serve = 1'b0;
        serve_p2    = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: enter_serve = bus.start;
            S_POINT: begin
                if (cnt_q == CW'(POINT_TICKS - 1) && score1_q != WIN && score2_q != WIN) begin
                    enter_serve = 1'b1;
                    serve_p2    = (ball_x_q == X_GOAL_R);   // player2 conceded, player2 serves
                end
            end
            default: ;
        endcase
    end

    // Match state machine, paddles, ball and scores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            paddle1_q  <= P_HOME;
            paddle2_q  <= P_HOME;
            ball_x_q   <= X_MID;
            ball_y_q   <= Y_MID;
            dx_q       <= 1'b1;
            dy_q       <= DY_0;
            score1_q   <= '0;
            score2_q   <= '0;
            winner_q   <= '0;
            cnt_q      <= '0;
`ifdef PONG_SPEEDUP_EN
            interval_q <= CW'(STEP_TICKS);
            rally_q    <= '0;
`endif
        end else if (bus.tick) begin
            if (state_q == S_SERVE || state_q == S_PLAY) begin
                paddle1_q <= paddle1_d;
                paddle2_q <= paddle2_d;
            end
            case (state_q)
                S_SERVE: begin
                    if (cnt_q == CW'(SERVE_TICKS - 1)) begin
                        state_q <= S_PLAY;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (step_due) begin
                        cnt_q    <= '0;
                        ball_x_q <= ball_x_d;
                        ball_y_q <= ball_y_d;
                        dx_q     <= dx_d;
                        dy_q     <= dy_d;
                        if (ball_x_d == '0) begin
                            state_q  <= S_POINT;
                            score2_q <= score2_q + 1'b1;
                        end else if (ball_x_d == X_GOAL_R) begin
                            state_q  <= S_POINT;
                            score1_q <= score1_q + 1'b1;
                        end
`ifdef PONG_SPEEDUP_EN
                        if (hit) begin
                            rally_q <= rally_q + 1'b1;
                            if (rally_q == 2'd3 && interval_q > CW'(1))
                                interval_q <= interval_q - 1'b1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_POINT: begin
                    if (cnt_q == CW'(POINT_TICKS - 1)) begin
                        cnt_q <= '0;
                        if (score1_q == WIN) begin
                            state_q  <= S_OVER;
                            winner_q <= 2'd1;
                        end else if (score2_q == WIN) begin
                            state_q  <= S_OVER;
                            winner_q <= 2'd2;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OVER: begin
                    if (bus.start) begin
                        score1_q <= '0;
                        score2_q <= '0;
                        winner_q <= '0;
                    end
                end
                default: ;
            endcase
            // Serve setup overrides whatever the state branch chose
            if (enter_serve) begin
                state_q    <= S_SERVE;
                ball_y_q   <= Y_MID;
                dy_q       <= DY_0;
                cnt_q      <= '0;
                ball_x_q   <= serve_p2 ? X_R1 : X_L1;
                dx_q       <= !serve_p2;
`ifdef PONG_SPEEDUP_EN
                interval_q <= CW'(STEP_TICKS);
                rally_q    <= '0;
`endif
            end
        end
    end

    assign bus.paddle1 = paddle1_q;
    assign bus.paddle2 = paddle2_q;
    assign bus.ball_x  = ball_x_q;
    assign bus.ball_y  = ball_y_q;
    assign bus.score1  = score1_q;
    assign bus.score2  = score2_q;
    assign bus.state   = state_q;
    assign bus.winner  = winner_q;
endmodule

// File: doc/pong_engine.md
# pong_engine

Parametrised two-player Pong game engine: owns paddle positions, ball position and direction, scores, and the match state machine for a COLS×ROWS LED board. It runs on the system clock and advances only on a one-cycle `tick` strobe from the game-rate divider, so the clock is never derived from logic. Its outputs feed the board renderer and the 7-segment score display. Compared with the fixed 8×8 version, it adds configurable geometry, paddle width, win score, serve/point delays and a proper match FSM.

## Interface
- COLS, 8: board columns (ball travel axis); ≥4
- ROWS, 8: board rows; ≥PADDLE_W+1
- PADDLE_W, 3: paddle length in cells; ≥2
- WIN_SCORE, 99: points to win; < 2**SCORE_W
- SCORE_W, 7: score counter width
- STEP_TICKS, 4: ticks per ball step in PLAY; ≥1
- SERVE_TICKS, 8: ticks held in SERVE
- POINT_TICKS, 8: ticks held in POINT
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; all registers to reset values
- tick  in  1  game-rate strobe, one clk wide
- start  in  1  level, sampled on tick
- btn_l1, btn_r1, btn_l2, btn_r2  in  1 each  paddle buttons (synchronised upstream)
- paddle1, paddle2  out  $clog2(ROWS)  lowest row covered by paddle
- ball_x  out  $clog2(COLS)  ball column
- ball_y  out  $clog2(ROWS)  ball row
- score1, score2  out  SCORE_W  scores
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- winner  out  2  0 none, 1 player1, 2 player2

## Operation
- Player1 paddle is at column 0 and player2 paddle at column COLS-1. A paddle at p covers rows p..p+PADDLE_W-1, with p in 0..ROWS-PADDLE_W.
- Paddles move in SERVE and PLAY only, one cell per tick. Left decrements, right increments; both pressed means no move. Position saturates at its limits.
- IDLE: start → SERVE, with server=player1.
- SERVE entry: ball_y=ROWS/2, dy=0, step counter cleared.
  - Server player1: ball_x=1, dx=+1.
  - Server player2: ball_x=COLS-2, dx=-1.
- SERVE: after SERVE_TICKS ticks → PLAY.
- PLAY: ball steps once every STEP_TICKS ticks. Per step, the next direction is computed in this order:
  1. Paddle check, done when (ball_x==1, dx=-1) or (ball_x==COLS-2, dx=+1). Let off = ball_y − paddle p.
     - If 0≤off<PADDLE_W: dx negated. off==0 gives dy=-1; off==PADDLE_W-1 gives dy=+1; otherwise dy is unchanged.
     - Otherwise: no change, and the ball enters the goal column.
  2. Wall check: ball_y==0 with dy=-1 gives dy=+1; ball_y==ROWS-1 with dy=+1 gives dy=-1.
  3. The ball moves by the new (dx, dy).
- A step that lands on column 0 → POINT and score2+1. A step that lands on column COLS-1 → POINT and score1+1. The increment happens on the same edge as the move.
- POINT: the ball is held in the goal column for POINT_TICKS ticks. Then:
  - If a score equals WIN_SCORE → OVER, with winner set.
  - Otherwise → SERVE, with server = the player who lost the point.
- OVER: start → scores 0, winner 0, server player1, SERVE.
- start is ignored in SERVE, PLAY and POINT.

## Timing
- Outputs are registered and change only on a clk edge where tick=1. Reset is the exception and takes effect immediately (asynchronous).
- Reset values:
  - state=IDLE, winner=0, score1=score2=0
  - paddle1=paddle2=(ROWS-PADDLE_W)/2
  - ball_x=COLS/2, ball_y=ROWS/2, dx=+1, dy=0, server=player1
- Latencies, measured from the tick:
  - start in IDLE: state=SERVE on the same edge.
  - SERVE → PLAY: on the SERVE_TICKS-th tick.
  - First ball move: STEP_TICKS ticks after entering PLAY.
- reset asserted mid-operation overrides tick and start on any edge.

## Configuration
- PONG_SPEEDUP_EN defined:
  - A rally counter counts paddle returns since the serve.
  - Every 4 returns, the step interval decreases by 1, with a minimum of 1.
  - The interval returns to STEP_TICKS at every SERVE entry and on reset.
- PONG_SPEEDUP_EN undefined: the step interval is constant at STEP_TICKS and there is no rally counter.

## Test plan
All scenarios use default parameters except where stated.
- **Paddle saturation.** Reset, enter SERVE, hold btn_l1 for 3 ticks → paddle1 goes 2,1,0,0.
- **Paddle both buttons.** Hold btn_l1 and btn_r1 together → paddle1 stays 2.
- **Edge return.** STEP_TICKS=1, serve by player1 with no buttons pressed. Ball reaches (6,4) with paddle2=2, so off=2 → next step (5,5), dx=-1, dy=+1.
- **Miss.** Same serve, then move paddle2 to 5 before the ball arrives → ball_x=7, state=POINT, score1=1. After POINT_TICKS ticks: SERVE, ball (6,4), dx=-1.
- **Match end.** WIN_SCORE=2. Second point to player1 → OVER, winner=1. start → score1=0, state=SERVE.
- **Reset mid-PLAY.** Assert reset mid-PLAY → all outputs take reset values immediately.
- **Speedup (PONG_SPEEDUP_EN).** STEP_TICKS=4. After 4 returns, the ball moves every 3 ticks; after the next serve, every 4 ticks.
